// File: rtl/mini_src_pkg.sv
// Shared constants for the Mini-SRC datapath: word width, ALU op codes and
// the immediate sign-extension helper used to build the C bus source.
package mini_src_pkg;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned ZWIDTH  = 2 * WIDTH;
    localparam int unsigned OPW     = 5;
    localparam int unsigned SHW     = 5;
    localparam int unsigned NUM_GPR = 16;
    localparam int unsigned IMM_W   = 19;

    localparam logic [OPW-1:0] OP_ADD   = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB   = 5'b00100;
    localparam logic [OPW-1:0] OP_SHR   = 5'b00101;
    localparam logic [OPW-1:0] OP_SRA   = 5'b00110;
    localparam logic [OPW-1:0] OP_SHL   = 5'b00111;
    localparam logic [OPW-1:0] OP_ROR   = 5'b01000;
    localparam logic [OPW-1:0] OP_ROL   = 5'b01001;
    localparam logic [OPW-1:0] OP_AND   = 5'b01010;
    localparam logic [OPW-1:0] OP_OR    = 5'b01011;
    localparam logic [OPW-1:0] OP_MUL   = 5'b01111;
    localparam logic [OPW-1:0] OP_DIV   = 5'b10000;
    localparam logic [OPW-1:0] OP_NEG   = 5'b10001;
    localparam logic [OPW-1:0] OP_NOT   = 5'b10010;
    localparam logic [OPW-1:0] OP_INCPC = 5'b11111;

    // C operand: IR[18:0] sign-extended to a full word.
    function automatic logic [WIDTH-1:0] sext_imm(input logic [WIDTH-1:0] ir);
        return {{(WIDTH - IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
    endfunction

endpackage

// File: rtl/data_path_alu.sv
// Combinational Mini-SRC ALU: A comes from Y, B from the bus, 64-bit result
// (upper half zero except for mul product and div remainder).
module data_path_alu
    import mini_src_pkg::*;
(
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [OPW-1:0]    op,
    output logic [ZWIDTH-1:0] result
);

    logic [SHW-1:0]           sh;
    logic [ZWIDTH-1:0]        dbl;
    logic [ZWIDTH-1:0]        ror_w;
    logic [ZWIDTH-1:0]        rol_w;
    logic [WIDTH-1:0]         sra_w;
    logic signed [ZWIDTH-1:0] a_ext;
    logic signed [ZWIDTH-1:0] b_ext;
    logic signed [ZWIDTH-1:0] prod;
    logic signed [WIDTH-1:0]  a_s;
    logic signed [WIDTH-1:0]  b_s;
    logic [WIDTH-1:0]         quo;
    logic [WIDTH-1:0]         rem;

    always_comb begin
        sh    = b[SHW-1:0];
        dbl   = {a, a};
        ror_w = dbl >> sh;
        rol_w = dbl << sh;
        sra_w = $signed(a) >>> sh;
        a_ext = {{WIDTH{a[WIDTH-1]}}, a};
        b_ext = {{WIDTH{b[WIDTH-1]}}, b};
        prod  = a_ext * b_ext;
        a_s   = a;
        b_s   = b;
        quo   = '0;
        rem   = '0;
        // Divide-by-zero leaves both halves at zero rather than trapping.
        if (b != '0) begin
            quo = a_s / b_s;
            rem = a_s % b_s;
        end

        result = '0;
        case (op)
            OP_ADD:   result = {{WIDTH{1'b0}}, a + b};
            OP_SUB:   result = {{WIDTH{1'b0}}, a - b};
            OP_SHR:   result = {{WIDTH{1'b0}}, a >> sh};
            OP_SRA:   result = {{WIDTH{1'b0}}, sra_w};
            OP_SHL:   result = {{WIDTH{1'b0}}, a << sh};
            OP_ROR:   result = {{WIDTH{1'b0}}, ror_w[WIDTH-1:0]};
            OP_ROL:   result = {{WIDTH{1'b0}}, rol_w[ZWIDTH-1:WIDTH]};
            OP_AND:   result = {{WIDTH{1'b0}}, a & b};
            OP_OR:    result = {{WIDTH{1'b0}}, a | b};
            OP_MUL:   result = prod;
            OP_DIV:   result = {rem, quo};
            OP_NEG:   result = {{WIDTH{1'b0}}, WIDTH'(0) - b};
            OP_NOT:   result = {{WIDTH{1'b0}}, ~b};
            OP_INCPC: result = {{WIDTH{1'b0}}, b + WIDTH'(1)};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/data_path.sv
// Mini-SRC single-bus datapath: register file, special registers, 64-bit Z,
// priority bus multiplexer and ALU.
module data_path
    import mini_src_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic [OPW-1:0]   alu_control,
    input  logic [WIDTH-1:0] Mdatain,
    input  logic             R0out,
    input  logic             R1out,
    input  logic             R2out,
    input  logic             R3out,
    input  logic             R4out,
    input  logic             R5out,
    input  logic             R6out,
    input  logic             R7out,
    input  logic             R8out,
    input  logic             R9out,
    input  logic             R10out,
    input  logic             R11out,
    input  logic             R12out,
    input  logic             R13out,
    input  logic             R14out,
    input  logic             R15out,
    input  logic             MDROut,
    input  logic             HIout,
    input  logic             LOout,
    input  logic             ZHIout,
    input  logic             ZLOout,
    input  logic             Pout,
    input  logic             Cout,
    input  logic             Yout,
    input  logic             IRen,
    input  logic             MARen,
    input  logic             MDRen,
    input  logic             Read,
    input  logic             Yen,
    input  logic             Pen,
    input  logic             ZHIen,
    input  logic             ZLOen,
    input  logic             HIen,
    input  logic             LOen,
    input  logic             R0en,
    input  logic             R1en,
    input  logic             R2en,
    input  logic             R3en,
    input  logic             R4en,
    input  logic             R5en,
    input  logic             R6en,
    input  logic             R7en,
    input  logic             R8en,
    input  logic             R9en,
    input  logic             R10en,
    input  logic             R11en,
    input  logic             R12en,
    input  logic             R13en,
    input  logic             R14en,
    input  logic             R15en,
    output logic [WIDTH-1:0] bus_out,
    output logic [WIDTH-1:0] ir_out,
    output logic [WIDTH-1:0] mar_out
);

    logic [NUM_GPR-1:0] gpr_out_c;
    logic [NUM_GPR-1:0] gpr_en_c;

    logic [WIDTH-1:0]  gpr_q [NUM_GPR];
    logic [WIDTH-1:0]  gpr_d [NUM_GPR];
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic [WIDTH-1:0]  pc_q, pc_d;
    logic [WIDTH-1:0]  ir_q, ir_d;
    logic [WIDTH-1:0]  mar_q, mar_d;
    logic [WIDTH-1:0]  mdr_q, mdr_d;
    logic [WIDTH-1:0]  y_q, y_d;
    logic [ZWIDTH-1:0] z_q, z_d;

    logic [WIDTH-1:0]  bus_c;
    logic [WIDTH-1:0]  c_c;
    logic [ZWIDTH-1:0] alu_res_c;

    assign gpr_out_c = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                        R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};
    assign gpr_en_c  = {R15en,  R14en,  R13en,  R12en,  R11en,  R10en,  R9en,  R8en,
                        R7en,   R6en,   R5en,   R4en,   R3en,   R2en,   R1en,  R0en};

    assign c_c = sext_imm(ir_q);

    // Bus mux: lowest priority assigned first so higher-priority sources win.
    always_comb begin
        bus_c = '0;
        if (Yout)   bus_c = y_q;
        if (Cout)   bus_c = c_c;
        if (MDROut) bus_c = mdr_q;
        if (Pout)   bus_c = pc_q;
        if (ZLOout) bus_c = z_q[WIDTH-1:0];
        if (ZHIout) bus_c = z_q[ZWIDTH-1:WIDTH];
        if (LOout)  bus_c = lo_q;
        if (HIout)  bus_c = hi_q;
        for (int i = NUM_GPR - 1; i >= 0; i--) begin
            if (gpr_out_c[i]) bus_c = gpr_q[i];
        end
    end

    data_path_alu u_alu (
        .a      (y_q),
        .b      (bus_c),
        .op     (alu_control),
        .result (alu_res_c)
    );

    // Next-state: every register holds unless its enable is set.
    always_comb begin
        for (int i = 0; i < NUM_GPR; i++) begin
            gpr_d[i] = gpr_en_c[i] ? bus_c : gpr_q[i];
        end
        hi_d  = HIen  ? bus_c : hi_q;
        lo_d  = LOen  ? bus_c : lo_q;
        pc_d  = Pen   ? bus_c : pc_q;
        ir_d  = IRen  ? bus_c : ir_q;
        mar_d = MARen ? bus_c : mar_q;
        y_d   = Yen   ? bus_c : y_q;
        mdr_d = mdr_q;
        if (MDRen) mdr_d = Read ? Mdatain : bus_c;
        z_d = z_q;
        if (ZLOen) z_d[WIDTH-1:0]      = alu_res_c[WIDTH-1:0];
        if (ZHIen) z_d[ZWIDTH-1:WIDTH] = alu_res_c[ZWIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < NUM_GPR; i++) begin
                gpr_q[i] <= '0;
            end
            hi_q  <= '0;
            lo_q  <= '0;
            pc_q  <= '0;
            ir_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            y_q   <= '0;
            z_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_GPR; i++) begin
                gpr_q[i] <= gpr_d[i];
            end
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            y_q   <= y_d;
            z_q   <= z_d;
        end
    end

    assign bus_out = bus_c;
    assign ir_out  = ir_q;
    assign mar_out = mar_q;

endmodule

// File: tb/tb_data_path.sv
// Directed self-checking bench for the Mini-SRC datapath.
module tb_data_path;

    logic        clk = 1'b0;
    logic        clr;
    logic [4:0]  alu_control;
    logic [31:0] Mdatain;
    logic [15:0] r_out;
    logic [15:0] r_en;
    logic        MDROut, HIout, LOout, ZHIout, ZLOout, Pout, Cout, Yout;
    logic        IRen, MARen, MDRen, Read, Yen, Pen, ZHIen, ZLOen, HIen, LOen;
    logic [31:0] bus_out, ir_out, mar_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    data_path dut (
        .clk(clk), .clr(clr), .alu_control(alu_control), .Mdatain(Mdatain),
        .R0out(r_out[0]),   .R1out(r_out[1]),   .R2out(r_out[2]),   .R3out(r_out[3]),
        .R4out(r_out[4]),   .R5out(r_out[5]),   .R6out(r_out[6]),   .R7out(r_out[7]),
        .R8out(r_out[8]),   .R9out(r_out[9]),   .R10out(r_out[10]), .R11out(r_out[11]),
        .R12out(r_out[12]), .R13out(r_out[13]), .R14out(r_out[14]), .R15out(r_out[15]),
        .MDROut(MDROut), .HIout(HIout), .LOout(LOout), .ZHIout(ZHIout), .ZLOout(ZLOout),
        .Pout(Pout), .Cout(Cout), .Yout(Yout),
        .IRen(IRen), .MARen(MARen), .MDRen(MDRen), .Read(Read),
        .Yen(Yen), .Pen(Pen), .ZHIen(ZHIen), .ZLOen(ZLOen), .HIen(HIen), .LOen(LOen),
        .R0en(r_en[0]),   .R1en(r_en[1]),   .R2en(r_en[2]),   .R3en(r_en[3]),
        .R4en(r_en[4]),   .R5en(r_en[5]),   .R6en(r_en[6]),   .R7en(r_en[7]),
        .R8en(r_en[8]),   .R9en(r_en[9]),   .R10en(r_en[10]), .R11en(r_en[11]),
        .R12en(r_en[12]), .R13en(r_en[13]), .R14en(r_en[14]), .R15en(r_en[15]),
        .bus_out(bus_out), .ir_out(ir_out), .mar_out(mar_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        alu_control = 5'b00000;
        Mdatain = '0;
        r_out = '0;
        r_en = '0;
        {MDROut, HIout, LOout, ZHIout, ZLOout, Pout, Cout, Yout} = '0;
        {IRen, MARen, MDRen, Read, Yen, Pen, ZHIen, ZLOen, HIen, LOen} = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mdr(input logic [31:0] v);
        idle();
        Read = 1'b1; MDRen = 1'b1; Mdatain = v;
        tick();
        idle();
    endtask

    // Y <= yv, MDR <= bv (MDR drives its old value while reloading), then Z <= ALU(op).
    task automatic alu_op(input string tag, input logic [31:0] yv, input logic [31:0] bv,
                          input logic [4:0] op, input logic [31:0] exp_lo,
                          input logic [31:0] exp_hi);
        load_mdr(yv);
        MDROut = 1'b1; Yen = 1'b1; Read = 1'b1; MDRen = 1'b1; Mdatain = bv;
        #1 check({tag, "_rw_old"}, bus_out, yv);
        tick();
        idle();
        MDROut = 1'b1; alu_control = op; ZLOen = 1'b1; ZHIen = 1'b1;
        tick();
        idle();
        ZLOout = 1'b1;
        #1 check({tag, "_lo"}, bus_out, exp_lo);
        ZLOout = 1'b0; ZHIout = 1'b1;
        #1 check({tag, "_hi"}, bus_out, exp_hi);
        idle();
    endtask

    initial begin
        idle();
        clr = 1'b0;
        #7;
        check("rst_bus", bus_out, 32'h0);
        check("rst_ir", ir_out, 32'h0);
        check("rst_mar", mar_out, 32'h0);
        #2 clr = 1'b1;

        // Register loads through MDR
        load_mdr(32'h15);
        MDROut = 1'b1;
        #1 check("mdr_15", bus_out, 32'h15);
        r_en[2] = 1'b1;
        tick();
        load_mdr(32'h05);
        MDROut = 1'b1; r_en[3] = 1'b1;
        tick();
        load_mdr(32'h18);
        MDROut = 1'b1; r_en[1] = 1'b1;
        tick();
        idle(); r_out[2] = 1'b1;
        #1 check("r2", bus_out, 32'h15);
        idle(); r_out[3] = 1'b1;
        #1 check("r3", bus_out, 32'h05);
        idle(); r_out[1] = 1'b1;
        #1 check("r1", bus_out, 32'h18);

        // Instruction fetch
        idle(); Pout = 1'b1; MARen = 1'b1; ZLOen = 1'b1; alu_control = 5'b11111;
        #1 check("pc_init", bus_out, 32'h0);
        tick();
        check("mar_pc", mar_out, 32'h0);
        idle(); ZLOout = 1'b1; Pen = 1'b1; Read = 1'b1; MDRen = 1'b1; Mdatain = 32'h28918000;
        #1 check("zlo_inc", bus_out, 32'h1);
        tick();
        idle(); Pout = 1'b1;
        #1 check("pc_1", bus_out, 32'h1);
        idle(); MDROut = 1'b1; IRen = 1'b1;
        tick();
        check("ir_load", ir_out, 32'h28918000);
        idle(); Cout = 1'b1;
        #1 check("c_pos", bus_out, 32'h00018000);

        // add R1 = R2 + R3
        idle(); r_out[2] = 1'b1; Yen = 1'b1;
        tick();
        idle(); r_out[3] = 1'b1; alu_control = 5'b00011; ZLOen = 1'b1;
        tick();
        idle(); ZLOout = 1'b1; r_en[1] = 1'b1;
        #1 check("add_z", bus_out, 32'h1A);
        tick();
        idle(); r_out[1] = 1'b1; MARen = 1'b1;
        tick();
        check("mar_r1", mar_out, 32'h1A);
        idle(); r_out[1] = 1'b1; Yout = 1'b1;
        #1 check("prio_r1_y", bus_out, 32'h1A);
        idle();
        #1 check("no_src", bus_out, 32'h0);
        idle(); Yout = 1'b1;
        #1 check("y_15", bus_out, 32'h15);

        // Negative immediate sign extension
        load_mdr(32'h00040000);
        MDROut = 1'b1; IRen = 1'b1;
        tick();
        idle(); Cout = 1'b1;
        #1 check("c_neg", bus_out, 32'hFFFC0000);

        // ALU operations
        alu_op("mul",   32'hFFFFFFFE, 32'd3,        5'b01111, 32'hFFFFFFFA, 32'hFFFFFFFF);
        alu_op("div",   32'd17,       32'd5,        5'b10000, 32'd3,        32'd2);
        alu_op("div0",  32'd7,        32'd0,        5'b10000, 32'd0,        32'd0);
        alu_op("divn",  32'hFFFFFFF9, 32'd2,        5'b10000, 32'hFFFFFFFD, 32'hFFFFFFFF);
        alu_op("shr",   32'h80000001, 32'd1,        5'b00101, 32'h40000000, 32'h0);
        alu_op("sra",   32'h80000001, 32'd1,        5'b00110, 32'hC0000000, 32'h0);
        alu_op("ror",   32'h80000001, 32'd1,        5'b01000, 32'hC0000000, 32'h0);
        alu_op("rol",   32'h80000001, 32'd1,        5'b01001, 32'h00000003, 32'h0);
        alu_op("shl",   32'h80000001, 32'd1,        5'b00111, 32'h00000002, 32'h0);
        alu_op("shr0",  32'h80000001, 32'd32,       5'b00101, 32'h80000001, 32'h0);
        alu_op("ror0",  32'h80000001, 32'd32,       5'b01000, 32'h80000001, 32'h0);
        alu_op("and",   32'hF0F0F0F0, 32'hFF00FF00, 5'b01010, 32'hF000F000, 32'h0);
        alu_op("or",    32'hF0F0F0F0, 32'hFF00FF00, 5'b01011, 32'hFFF0FFF0, 32'h0);
        alu_op("sub",   32'hF0F0F0F0, 32'hFF00FF00, 5'b00100, 32'hF1EFF1F0, 32'h0);
        alu_op("neg",   32'hF0F0F0F0, 32'hFF00FF00, 5'b10001, 32'h00FF0100, 32'h0);
        alu_op("not",   32'hF0F0F0F0, 32'hFF00FF00, 5'b10010, 32'h00FF00FF, 32'h0);
        alu_op("incpc", 32'hF0F0F0F0, 32'hFF00FF00, 5'b11111, 32'hFF00FF01, 32'h0);
        alu_op("addw",  32'hFFFFFFFF, 32'd2,        5'b00011, 32'h00000001, 32'h0);
        alu_op("bad",   32'hF0F0F0F0, 32'hFF00FF00, 5'b00000, 32'h0,        32'h0);

        // HI/LO load paths
        idle(); r_out[1] = 1'b1; HIen = 1'b1;
        tick();
        idle(); r_out[2] = 1'b1; LOen = 1'b1;
        tick();
        idle(); HIout = 1'b1;
        #1 check("hi", bus_out, 32'h1A);
        idle(); LOout = 1'b1;
        #1 check("lo", bus_out, 32'h15);

        // Asynchronous clear between edges
        idle(); r_out[1] = 1'b1;
        #1 check("pre_clr", bus_out, 32'h1A);
        #1 clr = 1'b0;
        #1;
        check("clr_bus", bus_out, 32'h0);
        check("clr_ir", ir_out, 32'h0);
        check("clr_mar", mar_out, 32'h0);
        #1 clr = 1'b1;
        tick();
        check("post_r1", bus_out, 32'h0);
        idle(); MDROut = 1'b1;
        #1 check("post_mdr", bus_out, 32'h0);
        idle(); Yout = 1'b1;
        #1 check("post_y", bus_out, 32'h0);
        idle(); Pout = 1'b1;
        #1 check("post_pc", bus_out, 32'h0);
        idle(); ZHIout = 1'b1;
        #1 check("post_zhi", bus_out, 32'h0);
        idle(); HIout = 1'b1;
        #1 check("post_hi", bus_out, 32'h0);
        load_mdr(32'h77);
        MDROut = 1'b1;
        #1 check("reload", bus_out, 32'h77);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
